nios2_mul_seq: RTL and testbench
================================

# nios2_mul_seq

Sequencer and two-port arbiter for one shared 16x16 unsigned registered multiplier cell. The cell registers its product on `cell_en` and presents it one cycle later. Two requesters submit 32x32 unsigned multiplies, and the block returns either the low or the high 32 bits of the 64-bit product. It issues the 16-bit partial products to the cell one per cycle, accumulates them into a 64-bit sum, and holds the result under a valid/ready handshake. It sits between the custom-instruction or peripheral masters and a single DSP multiplier, replacing three or four parallel cells with one.

## Interface
Parameters:
- `FAIR`, default 1. 1 selects round-robin arbitration; 0 selects fixed priority, with req0 always winning.

Ports:
- `clk`, in, 1. Single clock; every register is on the rising edge.
- `reset`, in, 1. Synchronous, active-high.
- `req_valid`, in, 2. Per-requester request valid; bit i belongs to requester i.
- `req_ready`, out, 2. Per-requester accept.
- `req_a0`, `req_b0`, `req_a1`, `req_b1`, in, 32 each. Operands for requesters 0 and 1.
- `req_op`, in, 2. Per requester: 0 = MUL (low word), 1 = MULXUU (high word).
- `rsp_valid`, out, 1. Result valid.
- `rsp_ready`, in, 1. Result accept.
- `rsp_id`, out, 1. Index of the requester that owns the result.
- `rsp_data`, out, 32. Result word.
- `cell_a`, `cell_b`, out, 16 each. Multiplier cell operands.
- `cell_en`, out, 1. Multiplier cell register enable.
- `cell_p`, in, 32. Cell product, valid one cycle after `cell_en`.

## Operation
- States: IDLE, ISSUE, DRAIN and RESP. Reset enters IDLE.
- Grant is computed only in IDLE; `req_ready` is 0 in every other state.
  - One valid requester gets the grant.
  - If both are valid and `FAIR`=1, grant goes to the requester not served last. The last-served pointer resets to 1, so req0 wins the first tie.
  - If both are valid and `FAIR`=0, req0 wins.
  - `req_ready[i]` is high only for the granted requester.
- Accept means `req_valid[i]` and `req_ready[i]` are both high. On accept:
  - latch a, b, op and id;
  - clear the 64-bit accumulator;
  - set partial counter k=0 and update the pointer;
  - go to ISSUE.
- Partial-product schedule for a=`{ah,al}`, b=`{bh,bl}`:
  - k=0: al*bl, shift 0.
  - k=1: al*bh, shift 16.
  - k=2: ah*bl, shift 16.
  - k=3: ah*bh, shift 32.
- Partial count: MUL issues N=3 partials (k=0..2), because ah*bh cannot affect the low word. MULXUU issues N=4.
- ISSUE:
  - Drive `cell_a`/`cell_b` for partial k, set `cell_en`=1, then k++.
  - From the second ISSUE cycle on, add `cell_p` (shifted for partial k-1) to the accumulator.
  - After N cycles, go to DRAIN.
- DRAIN: `cell_en`=0; add the last partial; go to RESP.
- RESP:
  - `rsp_valid`=1.
  - `rsp_data` = op ? acc[63:32] : acc[31:0].
  - `rsp_id` = latched id.
  - Hold all three stable until `rsp_ready`, then go to IDLE.
- Arithmetic is unsigned; the accumulator is 64 bits and never overflows, since the maximum sum is below 2^64.
- Outside ISSUE: `cell_en`=0 and `cell_a`=`cell_b`=0.
- Reset values: `req_ready`=0 during the reset cycle, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `cell_en`=0, `cell_a`=`cell_b`=0, accumulator 0, k=0, pointer=1.

## Timing
- Accept at edge T → ISSUE occupies cycles T+1..T+N → DRAIN at T+N+1 → `rsp_valid` high from T+N+2.
  - MUL: first `rsp_valid` 5 cycles after accept.
  - MULXUU: first `rsp_valid` 6 cycles after accept.
- RESP→IDLE at the `rsp_ready` edge. The earliest next accept is the following edge, so back-to-back MULs run at 6 cycles per op.
- A request arriving while the block is busy waits with `req_valid` held. A requester that drops `req_valid` before grant is simply not served; no request is latched without a handshake.
- Reset asserted in any state:
  - next state is IDLE and `rsp_valid` drops on that edge;
  - any in-flight result is discarded, with no response;
  - the `cell_p` value arriving after reset is ignored.
- `rsp_ready` high while `rsp_valid` is low has no effect.

## Test plan
- MUL from req0, a=0x0001_0002, b=0x0003_0004 → `rsp_data`=0x000A_0008, `rsp_id`=0, `rsp_valid` rising 5 cycles after accept, exactly three `cell_en` pulses.
- MULXUU from req1, a=b=0xFFFF_FFFF → `rsp_data`=0xFFFF_FFFE, `rsp_id`=1, `rsp_valid` rising 6 cycles after accept, four `cell_en` pulses. The same operands as MUL → 0x0000_0001.
- Both requesters valid continuously with `FAIR`=1 → accepts alternate 0,1,0,1. With `FAIR`=0 → req0 is always served while it is valid.
- `rsp_ready` held low for 10 cycles in RESP → `rsp_valid`, `rsp_data` and `rsp_id` stay stable, `req_ready`=0 throughout, and no extra `cell_en` pulses occur.
- Reset pulsed during the second ISSUE cycle → block in IDLE with all outputs at reset values on the next cycle, and no response. A new MUL of 7x6 then returns 42 with normal latency.
- Random 32-bit operands and ops over 1000 transactions, with random `rsp_ready` stalls → every result matches the 64-bit reference product, split per op.

Source files
------------

// File: rtl/nios2_mul_seq.sv
// Shares one registered 16x16 multiplier cell between two requesters.
// Each 32x32 multiply is sequenced as 16-bit partial products into a 64-bit accumulator.
module nios2_mul_seq #(
  parameter int unsigned FAIR = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req_a0,
  input  logic [31:0] req_b0,
  input  logic [31:0] req_a1,
  input  logic [31:0] req_b1,
  input  logic [1:0]  req_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic [15:0] cell_a,
  output logic [15:0] cell_b,
  output logic        cell_en,
  input  logic [31:0] cell_p
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic        op_q, op_d, id_q, id_d, ptr_q, ptr_d;
  logic [63:0] acc_q, acc_d;
  logic [2:0]  k_q, k_d;

  logic [1:0]  grant;
  logic        gnt_id;
  logic [2:0]  n_parts;
  logic [1:0]  pk;
  logic [63:0] pp_shifted;

  // ptr_q holds the last-served requester; on a tie the other one wins.
  always_comb begin
    grant = '0;
    unique case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (FAIR != 0 && ptr_q == 1'b0) ? 2'b10 : 2'b01;
      default: grant = '0;
    endcase
  end

  assign gnt_id  = grant[1];
  assign n_parts = op_q ? 3'd4 : 3'd3;

  // Product on cell_p belongs to the partial issued last cycle; k=4 wraps to index 3.
  assign pk = 2'(k_q - 3'd1);

  always_comb begin
    pp_shifted = '0;
    unique case (pk)
      2'd0:    pp_shifted = {32'h0, cell_p};
      2'd1,
      2'd2:    pp_shifted = {16'h0, cell_p, 16'h0};
      default: pp_shifted = {cell_p, 32'h0};
    endcase
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    id_d      = id_q;
    ptr_d     = ptr_q;
    acc_d     = acc_q;
    k_d       = k_q;
    req_ready = '0;
    cell_en   = 1'b0;
    cell_a    = '0;
    cell_b    = '0;

    unique case (state_q)
      S_IDLE: begin
        req_ready = reset ? 2'b00 : grant;
        if (|(req_valid & req_ready)) begin
          a_d     = gnt_id ? req_a1 : req_a0;
          b_d     = gnt_id ? req_b1 : req_b0;
          op_d    = req_op[gnt_id];
          id_d    = gnt_id;
          ptr_d   = gnt_id;
          acc_d   = '0;
          k_d     = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cell_en = 1'b1;
        unique case (k_q[1:0])
          2'd0:    begin cell_a = a_q[15:0];  cell_b = b_q[15:0];  end
          2'd1:    begin cell_a = a_q[15:0];  cell_b = b_q[31:16]; end
          2'd2:    begin cell_a = a_q[31:16]; cell_b = b_q[15:0];  end
          default: begin cell_a = a_q[31:16]; cell_b = b_q[31:16]; end
        endcase
        k_d = k_q + 3'd1;
        if (k_q != 3'd0) begin
          acc_d = acc_q + pp_shifted;
        end
        if (k_d == n_parts) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        acc_d   = acc_q + pp_shifted;
        state_d = S_RESP;
      end
      default: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  assign rsp_valid = (state_q == S_RESP);
  assign rsp_id    = rsp_valid & id_q;
  assign rsp_data  = rsp_valid ? (op_q ? acc_q[63:32] : acc_q[31:0]) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 1'b0;
      id_q    <= 1'b0;
      ptr_q   <= 1'b1;
      acc_q   <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      acc_q   <= acc_d;
      k_q     <= k_d;
    end
  end

endmodule

// File: tb/tb_nios2_mul_seq.sv
// Scoreboard bench for nios2_mul_seq: round-robin instance plus a fixed-priority instance,
// each with a behavioural registered 16x16 multiplier cell.
module tb_nios2_mul_seq;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [31:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
  logic [1:0]  req_op = '0;
  logic        rsp_valid, rsp_id;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic [15:0] cell_a, cell_b;
  logic        cell_en;
  logic [31:0] cell_p = '0;

  logic [1:0]  req_valid2 = '0;
  logic [1:0]  req_ready2;
  logic        rsp_valid2, rsp_id2;
  logic        rsp_ready2 = 1'b1;
  logic [31:0] rsp_data2;
  logic [15:0] cell_a2, cell_b2;
  logic        cell_en2;
  logic [31:0] cell_p2 = '0;

  nios2_mul_seq #(.FAIR(1)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .cell_a(cell_a), .cell_b(cell_b), .cell_en(cell_en), .cell_p(cell_p)
  );

  nios2_mul_seq #(.FAIR(0)) u_dut_fp (
    .clk(clk), .reset(reset),
    .req_valid(req_valid2), .req_ready(req_ready2),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_op(req_op),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2), .rsp_id(rsp_id2), .rsp_data(rsp_data2),
    .cell_a(cell_a2), .cell_b(cell_b2), .cell_en(cell_en2), .cell_p(cell_p2)
  );

  always @(posedge clk) begin
    if (cell_en)  cell_p  <= {16'h0, cell_a}  * {16'h0, cell_b};
    if (cell_en2) cell_p2 <= {16'h0, cell_a2} * {16'h0, cell_b2};
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [32:0] model(input int id, input logic [31:0] a, input logic [31:0] b,
                                        input logic op);
    logic [63:0] p;
    p = {32'h0, a} * {32'h0, b};
    return {id[0], op ? p[63:32] : p[31:0]};
  endfunction

  logic [32:0] sb[$];
  int          acc_log[$];
  int          acc_log2[$];
  int unsigned cyc = 0, acc_cyc = 0, last_lat = 0, cell_cnt = 0;
  logic        prev_valid = 1'b0;
  logic [31:0] last_data = '0;
  logic        last_id = 1'b0;
  logic        rnd = 1'b0;

  always @(negedge clk) begin
    logic [32:0] e;
    cyc++;
    if (cell_en) cell_cnt++;
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          sb.push_back(model(i, i == 0 ? req_a0 : req_a1, i == 0 ? req_b0 : req_b1, req_op[i]));
          acc_log.push_back(i);
          acc_cyc = cyc;
        end
        if (req_valid2[i] && req_ready2[i]) acc_log2.push_back(i);
      end
      if (rsp_valid && !prev_valid) last_lat = cyc - acc_cyc;
      if (rsp_valid && rsp_ready) begin
        last_data = rsp_data;
        last_id   = rsp_id;
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("rsp_id", rsp_id, e[32]);
          chk("rsp_data", rsp_data, e[31:0]);
        end
      end
    end
    prev_valid = rsp_valid;
  end

  initial forever begin
    @(posedge clk); #1;
    if (rnd) rsp_ready = 1'($urandom_range(0, 1));
  end

  task automatic do_req(input int id, input logic [31:0] a, input logic [31:0] b, input logic op);
    bit ok = 0;
    if (id == 0) begin req_a0 = a; req_b0 = b; end
    else begin req_a1 = a; req_b1 = b; end
    req_op[id]    = op;
    req_valid[id] = 1'b1;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clk);
      if (req_ready[id]) ok = 1;
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_drain();
    bit ok = 0;
    for (int t = 0; t < 400 && !ok; t++) begin
      @(negedge clk);
      if (sb.size() == 0 && !rsp_valid) ok = 1;
    end
    if (!ok) chk("drain_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_rsp_id"}, rsp_id, 0);
    chk({tag, "_cell_en"}, cell_en, 0);
    chk({tag, "_cell_a"}, cell_a, 0);
    chk({tag, "_cell_b"}, cell_b, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned c0;
    int          base;
    bit          ok, seen;
    logic [31:0] d0;
    logic        i0;

    // Reset with both requests asserted: nothing may be granted.
    req_valid = 2'b11;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b0; req_valid = '0; rsp_ready = 1'b1;

    c0 = cell_cnt;
    do_req(0, 32'h0001_0002, 32'h0003_0004, 1'b0);
    wait_drain();
    chk("mul_data", last_data, 32'h000A_0008);
    chk("mul_id", last_id, 0);
    chk("mul_lat", last_lat, 5);
    chk("mul_pulses", cell_cnt - c0, 3);

    c0 = cell_cnt;
    do_req(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_drain();
    chk("mulxuu_data", last_data, 32'hFFFF_FFFE);
    chk("mulxuu_id", last_id, 1);
    chk("mulxuu_lat", last_lat, 6);
    chk("mulxuu_pulses", cell_cnt - c0, 4);

    do_req(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_drain();
    chk("mul_ones_data", last_data, 32'h0000_0001);

    // Round-robin: last served was req1, so order is 0,1,0,1.
    base = acc_log.size();
    req_a0 = 32'd1234; req_b0 = 32'd5678; req_a1 = 32'hDEAD_BEEF; req_b1 = 32'h0000_1001;
    req_op = 2'b10;
    req_valid = 2'b11;
    ok = 0;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      if (acc_log.size() >= base + 4) ok = 1;
    end
    @(posedge clk); #1;
    req_valid = '0;
    wait_drain();
    chk("fair_count", acc_log.size() - base, 4);
    for (int i = 0; i < 4; i++) chk("fair_order", acc_log[base + i], i % 2);

    // Fixed priority instance: req0 always wins while held valid.
    base = acc_log2.size();
    req_valid2 = 2'b11;
    ok = 0;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      if (acc_log2.size() >= base + 3) ok = 1;
    end
    @(posedge clk); #1;
    req_valid2 = '0;
    chk("fp_count", acc_log2.size() - base, 3);
    for (int i = 0; i < 3; i++) chk("fp_order", acc_log2[base + i], 0);
    repeat (10) @(posedge clk);
    #1;

    // Response stall with req1 waiting.
    rsp_ready = 1'b0;
    c0 = cell_cnt;
    do_req(0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    req_a1 = 32'd3; req_b1 = 32'd5; req_op[1] = 1'b0;
    req_valid[1] = 1'b1;
    ok = 0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (rsp_valid) ok = 1;
    end
    chk("stall_rsp_seen", ok, 1);
    d0 = rsp_data; i0 = rsp_id;
    chk("stall_data_ref", d0, 33'(model(0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1)) & 33'hFFFF_FFFF);
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      chk("stall_valid", rsp_valid, 1);
      chk("stall_data", rsp_data, d0);
      chk("stall_id", rsp_id, i0);
      chk("stall_req_ready", req_ready, 0);
    end
    chk("stall_pulses", cell_cnt - c0, 4);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    do_req(1, 32'd3, 32'd5, 1'b0);
    wait_drain();
    chk("after_stall_data", last_data, 15);
    chk("after_stall_id", last_id, 1);

    // Reset during the second ISSUE cycle discards the operation.
    do_req(0, 32'd100, 32'd200, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk_idle_outputs("midreset");
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
    end
    chk("no_rsp_after_reset", seen, 0);
    @(posedge clk); #1;
    do_req(0, 32'd7, 32'd6, 1'b0);
    wait_drain();
    chk("post_reset_data", last_data, 42);
    chk("post_reset_lat", last_lat, 5);

    // Random operands, ops and requesters with random response stalls.
    rnd = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      do_req(int'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)));
    end
    wait_drain();
    rnd = 1'b0;
    rsp_ready = 1'b1;
    chk("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
